// File: rtl/cu_program_sequencer_if.sv
// Instruction issue / result channel between the program sequencer and the
// 8-bit compute unit.
//   issue_instr  16  instruction presented to the unit
//   issue_valid   1  issue_instr is valid (unit enable)
//   issue_ready   1  unit accepts the presented instruction
//   result_in     8  unit result, valid the cycle after a transfer
// Handshake: a transfer happens on a rising edge where issue_valid and
// issue_ready are both high. While issue_valid is high and issue_ready is
// low, issue_instr is held stable. The unit returns the result one cycle
// after the transfer, with no separate valid strobe.
interface cu_program_sequencer_if;
  logic [15:0] issue_instr;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  result_in;

  modport master (output issue_instr, output issue_valid,
                  input issue_ready, input result_in);
  modport slave  (input issue_instr, input issue_valid,
                  output issue_ready, output result_in);
endinterface

// File: rtl/cu_program_sequencer.sv
// Program sequencer for the 8-bit compute unit. The host loads up to DEPTH
// 16-bit instructions, then starts a run of prog_len slots repeated
// loop_cnt+1 times. Each instruction is issued over a valid/ready channel
// and the unit's result is captured the cycle after each transfer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_en/addr/data     program slot write (honoured only when idle)
//   prog_len, loop_cnt  run length and extra passes, sampled at start
//   start, abort        begin a run / stop immediately (abort wins)
//   cu                  issue/result channel to the compute unit
//   last_result         most recently captured result
//   result_cnt          results captured since start (wraps)
//   pc                  slot currently presented
//   busy, done          running / one-cycle completion pulse
//   dbg_state           FSM state for observation
module cu_program_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [15:0]         wr_data,
  input  logic [ADDR_W:0]     prog_len,
  input  logic [3:0]          loop_cnt,
  input  logic                start,
  input  logic                abort,
  cu_program_sequencer_if.master cu,
  output logic [7:0]          last_result,
  output logic [7:0]          result_cnt,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        passes_q, passes_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              rv_q, rv_d;
  logic [7:0]        last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];

  logic              xfer;
  logic              at_last;
  logic [ADDR_W:0]   len_clamped;

  assign xfer        = (state_q == S_RUN) && cu.issue_ready;
  assign at_last     = ({1'b0, pc_q} == (len_q - 1'b1));
  assign len_clamped = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    passes_d = passes_q;
    len_d    = len_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    rv_d     = xfer;

    // The result of the previous cycle's transfer arrives now, whatever
    // the current state is.
    if (rv_q) begin
      last_d = cu.result_in;
      cnt_d  = cnt_q + 8'd1;
    end

    if (abort) begin
      // Abort also suppresses any start/write in the same cycle, and drops
      // the result of a transfer that happens on this edge.
      state_d = S_IDLE;
      pc_d    = '0;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_en) mem_d[wr_addr] = wr_data;
          if (start) begin
            cnt_d    = 8'd0;
            pc_d     = '0;
            passes_d = loop_cnt;
            len_d    = len_clamped;
            state_d  = (len_clamped == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (!at_last) begin
              pc_d = pc_q + ADDR_W'(1);
            end else if (passes_q != 4'd0) begin
              pc_d     = '0;
              passes_d = passes_q - 4'd1;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      passes_q <= '0;
      len_q    <= '0;
      rv_q     <= 1'b0;
      last_q   <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      passes_q <= passes_d;
      len_q    <= len_d;
      rv_q     <= rv_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  // Instruction follows pc combinationally; pc only moves on a transfer,
  // so the instruction is stable while the unit stalls.
  assign cu.issue_instr = (state_q == S_RUN) ? mem_q[pc_q] : 16'h0000;
  assign cu.issue_valid = (state_q == S_RUN);
  assign last_result    = last_q;
  assign result_cnt     = cnt_q;
  assign pc             = pc_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cu_program_sequencer.sv
module tb_cu_program_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  prog_len;
  logic [3:0]  loop_cnt;
  logic        start;
  logic        abort;
  logic [7:0]  last_result;
  logic [7:0]  result_cnt;
  logic [2:0]  pc;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  cu_program_sequencer_if ifc ();

  cu_program_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .prog_len   (prog_len),
    .loop_cnt   (loop_cnt),
    .start      (start),
    .abort      (abort),
    .cu         (ifc.master),
    .last_result(last_result),
    .result_cnt (result_cnt),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compute unit model ----------------
  // op1 LDI tgt<=imm, op2 ADD tgt<=src0+src1, op3 SUB; others return imm.
  logic [7:0] ur [16];
  int xfers = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      ifc.result_in <= 8'h00;
      for (int i = 0; i < 16; i++) ur[i] = 8'h00;
    end else if (ifc.issue_valid && ifc.issue_ready) begin
      logic [15:0] ins;
      logic [7:0]  r;
      ins = ifc.issue_instr;
      case (ins[15:12])
        4'd1:    r = ins[7:0];
        4'd2:    r = ur[ins[7:4]] + ur[ins[3:0]];
        4'd3:    r = ur[ins[7:4]] - ur[ins[3:0]];
        default: r = ins[7:0];
      endcase
      if (ins[15:12] >= 4'd1 && ins[15:12] <= 4'd3) ur[ins[11:8]] = r;
      ifc.result_in <= r;
      xfers++;
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  typedef struct packed {
    logic [2:0]  pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        exp_q[$];       // transfers still to be issued in this run
  logic [15:0] m_mem [8];
  logic        m_init = 1'b0;
  logic        m_busy;
  int          m_tail;         // 0 issuing, 1 drain cycle, 2 done cycle
  logic        m_pend;         // a result arrives in the current cycle
  logic [7:0]  m_last;
  logic [7:0]  m_cnt;
  int          dones = 0;
  logic        valid_seen = 1'b0;

  always @(posedge clk) begin
    logic ev, xf;
    int   l;
    ev = m_init && m_busy && (m_tail == 0) && (exp_q.size() > 0);
    xf = ev && ifc.issue_ready;
    if (done) dones++;
    if (ifc.issue_valid) valid_seen = 1'b1;
    if (m_init) begin
      chk("busy",        32'(busy),            32'(m_busy));
      chk("done",        32'(done),            32'(m_tail == 2));
      chk("issue_valid", 32'(ifc.issue_valid), 32'(ev));
      chk("last_result", 32'(last_result),     32'(m_last));
      chk("result_cnt",  32'(result_cnt),      32'(m_cnt));
      if (ev) begin
        chk("issue_instr", 32'(ifc.issue_instr), 32'(exp_q[0].instr));
        chk("pc",          32'(pc),              32'(exp_q[0].pc));
      end
    end
    if (!rst_n) begin
      m_init = 1'b1;
      m_busy = 1'b0; m_tail = 0; m_pend = 1'b0; m_last = 8'h00; m_cnt = 8'h00;
      exp_q.delete();
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    end else if (m_init) begin
      if (m_pend) begin
        m_last = ifc.result_in;
        m_cnt  = m_cnt + 8'd1;
      end
      m_pend = xf;
      if (abort) begin
        m_busy = 1'b0; m_tail = 0; m_pend = 1'b0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (wr_en) m_mem[wr_addr] = wr_data;
        if (start) begin
          l = (prog_len > 4'd8) ? 8 : int'(prog_len);
          m_cnt  = 8'h00;
          m_busy = 1'b1;
          for (int p = 0; p <= int'(loop_cnt) && l > 0; p++)
            for (int i = 0; i < l; i++)
              exp_q.push_back('{pc: 3'(i), instr: m_mem[i]});
          m_tail = (l == 0) ? 2 : 0;
        end
      end else if (m_tail == 2) begin
        m_busy = 1'b0; m_tail = 0;
      end else if (m_tail == 1) begin
        m_tail = 2;
      end else if (xf) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_tail = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_slot(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] len, input logic [3:0] lp);
    prog_len = len; loop_cnt = lp; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick(1);
      k++;
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", k);
    end
  endtask

  task automatic clr_counts();
    xfers = 0; dones = 0; valid_seen = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    prog_len = '0; loop_cnt = '0; start = 1'b0; abort = 1'b0;
    ifc.issue_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // reset state
    chk("rst_busy",  32'(busy),            32'd0);
    chk("rst_valid", 32'(ifc.issue_valid), 32'd0);
    chk("rst_pc",    32'(pc),              32'd0);
    chk("rst_last",  32'(last_result),     32'd0);
    chk("rst_cnt",   32'(result_cnt),      32'd0);
    chk("rst_done",  32'(done),            32'd0);

    // 1: basic three-instruction program
    write_slot(3'd0, 16'h1105);
    write_slot(3'd1, 16'h1203);
    write_slot(3'd2, 16'h2312);
    clr_counts();
    start_run(4'd3, 4'd0);
    wait_idle();
    chk("t1_xfers", 32'(xfers),       32'd3);
    chk("t1_last",  32'(last_result), 32'h08);
    chk("t1_cnt",   32'(result_cnt),  32'd3);
    chk("t1_dones", 32'(dones),       32'd1);

    // 2: stall two cycles at pc=1
    clr_counts();
    start_run(4'd3, 4'd0);
    tick(1);
    ifc.issue_ready = 1'b0;
    tick(2);
    chk("t2_hold_instr", 32'(ifc.issue_instr), 32'h1203);
    chk("t2_hold_pc",    32'(pc),              32'd1);
    ifc.issue_ready = 1'b1;
    wait_idle();
    chk("t2_xfers", 32'(xfers),       32'd3);
    chk("t2_last",  32'(last_result), 32'h08);

    // 3: len=2 with two extra passes
    clr_counts();
    start_run(4'd2, 4'd2);
    wait_idle();
    chk("t3_xfers", 32'(xfers),       32'd6);
    chk("t3_cnt",   32'(result_cnt),  32'd6);
    chk("t3_dones", 32'(dones),       32'd1);
    chk("t3_last",  32'(last_result), 32'h03);

    // 4: abort at pc=1, then rerun
    clr_counts();
    start_run(4'd3, 4'd0);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t4_valid", 32'(ifc.issue_valid), 32'd0);
    chk("t4_busy",  32'(busy),            32'd0);
    tick(4);
    chk("t4_dones", 32'(dones), 32'd0);
    clr_counts();
    start_run(4'd3, 4'd0);
    chk("t4_rerun_pc", 32'(pc), 32'd0);
    wait_idle();
    chk("t4_xfers", 32'(xfers),      32'd3);
    chk("t4_cnt",   32'(result_cnt), 32'd3);

    // 5: zero length, then clamped length
    clr_counts();
    start_run(4'd0, 4'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_done", 32'(done), 32'd1);
    tick(1);
    chk("t5_idle",  32'(busy),       32'd0);
    chk("t5_valid", 32'(valid_seen), 32'd0);
    clr_counts();
    start_run(4'd12, 4'd0);
    wait_idle();
    chk("t5_clamp_xfers", 32'(xfers),      32'd8);
    chk("t5_clamp_cnt",   32'(result_cnt), 32'd8);

    // 6: write while busy is ignored
    start_run(4'd3, 4'd0);
    write_slot(3'd0, 16'hFFFF);
    wait_idle();
    start_run(4'd3, 4'd0);
    chk("t6_slot0", 32'(ifc.issue_instr), 32'h1105);
    wait_idle();

    // 6b: reset mid-run clears everything including slots
    start_run(4'd3, 4'd0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_valid", 32'(ifc.issue_valid), 32'd0);
    chk("t6_rst_busy",  32'(busy),            32'd0);
    chk("t6_rst_cnt",   32'(result_cnt),      32'd0);
    chk("t6_rst_last",  32'(last_result),     32'd0);
    chk("t6_rst_pc",    32'(pc),              32'd0);
    rst_n = 1'b1;
    tick(1);

    // write and start in the same cycle: run sees the new slot 0
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1107;
    prog_len = 4'd2; loop_cnt = 4'd0; start = 1'b1;
    tick(1);
    wr_en = 1'b0; start = 1'b0;
    chk("t6_wrstart_instr", 32'(ifc.issue_instr), 32'h1107);
    tick(1);
    chk("t6_slot1_zero", 32'(ifc.issue_instr), 32'h0000);
    chk("t6_slot1_pc",   32'(pc),              32'd1);
    wait_idle();
    chk("t6_cnt", 32'(result_cnt), 32'd2);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
